// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: writeback FSM states, store sizes and
// exception cause codes.
package pipeline_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STORE = 1'b1
    } wb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [5:0] EXC_INST_MISALIGNED    = 6'd0;
    localparam logic [5:0] EXC_INST_ACCESS_FAULT  = 6'd1;
    localparam logic [5:0] EXC_ILLEGAL_INST       = 6'd2;
    localparam logic [5:0] EXC_BREAKPOINT         = 6'd3;
    localparam logic [5:0] EXC_LOAD_MISALIGNED    = 6'd4;
    localparam logic [5:0] EXC_LOAD_ACCESS_FAULT  = 6'd5;
    localparam logic [5:0] EXC_STORE_MISALIGNED   = 6'd6;
    localparam logic [5:0] EXC_STORE_ACCESS_FAULT = 6'd7;
    localparam logic [5:0] EXC_ECALL_M            = 6'd11;

endpackage

// File: rtl/writeback_retire_counter.sv
// 64-bit retired-instruction counter; wraps naturally from all-ones to zero.
module retire_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 64'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: register commit, store handshake, and flush/trap
// generation for jumps and exceptions. Every output comes straight from a flop.
module writeback
    import pipeline_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ex_valid,
    output logic        ex_stall,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_rd_val,
    input  logic [31:0] ex_inst_pc,
    input  logic [31:0] ex_jump_pc,
    input  logic        ex_jump,
    input  logic [5:0]  ex_exception_num,
    input  logic [31:0] ex_exception_val,
    input  logic        ex_exception_valid,
    input  logic [31:0] ex_store_addr,
    input  logic [31:0] ex_store_val,
    input  logic [1:0]  ex_store_size,
    input  logic        ex_store_valid,

    output logic [31:0] mem_store_addr,
    output logic [31:0] mem_store_val,
    output logic [1:0]  mem_store_size,
    output logic        mem_store_valid,
    input  logic        mem_store_done,
    input  logic        mem_store_access_fault,

    output logic        reg_write_en,
    output logic [4:0]  reg_write_addr,
    output logic [31:0] reg_write_val,

    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        trap_valid,
    output logic [5:0]  trap_cause,
    output logic [31:0] trap_val,
    output logic [31:0] trap_epc,
    output logic [63:0] retire_count
);

    wb_state_t   state_q, state_d;
    logic        ex_stall_q, ex_stall_d;
    logic [31:0] st_addr_q, st_addr_d;
    logic [31:0] st_val_q, st_val_d;
    logic [1:0]  st_size_q, st_size_d;
    logic        st_req_q, st_req_d;
    logic [31:0] st_pc_q, st_pc_d;
    logic        st_jump_q, st_jump_d;
    logic [31:0] st_jump_pc_q, st_jump_pc_d;
    logic        wen_q, wen_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wval_q, wval_d;
    logic        flush_q, flush_d;
    logic [31:0] redirect_q, redirect_d;
    logic        trap_q, trap_d;
    logic [5:0]  cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] epc_q, epc_d;
    logic        retire_inc;
    logic        accept;

    assign accept = ex_valid && !ex_stall_q && !flush_q;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; a missing default would infer a latch.
    always_comb begin
        state_d      = state_q;
        st_addr_d    = st_addr_q;
        st_val_d     = st_val_q;
        st_size_d    = st_size_q;
        st_req_d     = st_req_q;
        st_pc_d      = st_pc_q;
        st_jump_d    = st_jump_q;
        st_jump_pc_d = st_jump_pc_q;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        wval_d       = wval_q;
        flush_d      = 1'b0;
        redirect_d   = redirect_q;
        trap_d       = 1'b0;
        cause_d      = cause_q;
        tval_d       = tval_q;
        epc_d        = epc_q;
        retire_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ex_exception_valid) begin
                        trap_d     = 1'b1;
                        cause_d    = ex_exception_num;
                        tval_d     = ex_exception_val;
                        epc_d      = ex_inst_pc;
                        flush_d    = 1'b1;
                        redirect_d = TRAP_VECTOR;
                    end else if (ex_store_valid) begin
                        state_d      = STORE;
                        st_addr_d    = ex_store_addr;
                        st_val_d     = ex_store_val;
                        st_size_d    = ex_store_size;
                        st_req_d     = 1'b1;
                        st_pc_d      = ex_inst_pc;
                        st_jump_d    = ex_jump;
                        st_jump_pc_d = ex_jump_pc;
                    end else begin
                        wen_d      = (ex_rd != 5'd0);
                        waddr_d    = ex_rd;
                        wval_d     = ex_rd_val;
                        retire_inc = 1'b1;
                        if (ex_jump) begin
                            flush_d    = 1'b1;
                            redirect_d = ex_jump_pc;
                        end
                    end
                end
            end
            STORE: begin
                // A fault wins even when done is reported in the same cycle.
                if (mem_store_access_fault) begin
                    state_d    = IDLE;
                    st_req_d   = 1'b0;
                    trap_d     = 1'b1;
                    cause_d    = EXC_STORE_ACCESS_FAULT;
                    tval_d     = st_addr_q;
                    epc_d      = st_pc_q;
                    flush_d    = 1'b1;
                    redirect_d = TRAP_VECTOR;
                end else if (mem_store_done) begin
                    state_d    = IDLE;
                    st_req_d   = 1'b0;
                    retire_inc = 1'b1;
                    if (st_jump_q) begin
                        flush_d    = 1'b1;
                        redirect_d = st_jump_pc_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ex_stall_d = (state_d == STORE) || flush_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // their next-state values from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ex_stall_q   <= 1'b0;
            st_addr_q    <= '0;
            st_val_q     <= '0;
            st_size_q    <= '0;
            st_req_q     <= 1'b0;
            st_pc_q      <= '0;
            st_jump_q    <= 1'b0;
            st_jump_pc_q <= '0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wval_q       <= '0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            trap_q       <= 1'b0;
            cause_q      <= '0;
            tval_q       <= '0;
            epc_q        <= '0;
        end else begin
            state_q      <= state_d;
            ex_stall_q   <= ex_stall_d;
            st_addr_q    <= st_addr_d;
            st_val_q     <= st_val_d;
            st_size_q    <= st_size_d;
            st_req_q     <= st_req_d;
            st_pc_q      <= st_pc_d;
            st_jump_q    <= st_jump_d;
            st_jump_pc_q <= st_jump_pc_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wval_q       <= wval_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            trap_q       <= trap_d;
            cause_q      <= cause_d;
            tval_q       <= tval_d;
            epc_q        <= epc_d;
        end
    end

    retire_counter u_retire_counter (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (retire_inc),
        .count_o (retire_count)
    );

    assign ex_stall        = ex_stall_q;
    assign mem_store_addr  = st_addr_q;
    assign mem_store_val   = st_val_q;
    assign mem_store_size  = st_size_q;
    assign mem_store_valid = st_req_q;
    assign reg_write_en    = wen_q;
    assign reg_write_addr  = waddr_q;
    assign reg_write_val   = wval_q;
    assign flush           = flush_q;
    assign redirect_pc     = redirect_q;
    assign trap_valid      = trap_q;
    assign trap_cause      = cause_q;
    assign trap_val        = tval_q;
    assign trap_epc        = epc_q;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios then randomized
// transactions checked against a transaction-level expectation model.
module tb_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_stall;
    logic [4:0]  ex_rd;
    logic [31:0] ex_rd_val, ex_inst_pc, ex_jump_pc;
    logic        ex_jump;
    logic [5:0]  ex_exception_num;
    logic [31:0] ex_exception_val;
    logic        ex_exception_valid;
    logic [31:0] ex_store_addr, ex_store_val;
    logic [1:0]  ex_store_size;
    logic        ex_store_valid;
    logic [31:0] mem_store_addr, mem_store_val;
    logic [1:0]  mem_store_size;
    logic        mem_store_valid, mem_store_done, mem_store_access_fault;
    logic        reg_write_en;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_val;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [5:0]  trap_cause;
    logic [31:0] trap_val, trap_epc;
    logic [63:0] retire_count;

    localparam logic [31:0] TV = 32'h0000_0100;

    writeback #(.TRAP_VECTOR(TV)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_rd(ex_rd), .ex_rd_val(ex_rd_val),
        .ex_inst_pc(ex_inst_pc), .ex_jump_pc(ex_jump_pc), .ex_jump(ex_jump),
        .ex_exception_num(ex_exception_num), .ex_exception_val(ex_exception_val),
        .ex_exception_valid(ex_exception_valid), .ex_store_addr(ex_store_addr),
        .ex_store_val(ex_store_val), .ex_store_size(ex_store_size),
        .ex_store_valid(ex_store_valid), .mem_store_addr(mem_store_addr),
        .mem_store_val(mem_store_val), .mem_store_size(mem_store_size),
        .mem_store_valid(mem_store_valid), .mem_store_done(mem_store_done),
        .mem_store_access_fault(mem_store_access_fault), .reg_write_en(reg_write_en),
        .reg_write_addr(reg_write_addr), .reg_write_val(reg_write_val), .flush(flush),
        .redirect_pc(redirect_pc), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_val(trap_val), .trap_epc(trap_epc), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] exp_retire = 64'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 0; ex_rd = 0; ex_rd_val = 0; ex_inst_pc = 0; ex_jump_pc = 0;
        ex_jump = 0; ex_exception_num = 0; ex_exception_val = 0; ex_exception_valid = 0;
        ex_store_addr = 0; ex_store_val = 0; ex_store_size = 0; ex_store_valid = 0;
        mem_store_done = 0; mem_store_access_fault = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, ex_stall, 0);
        check({tag, "_mem"}, {mem_store_addr, mem_store_val, mem_store_size, mem_store_valid}, 0);
        check({tag, "_reg"}, {reg_write_en, reg_write_addr, reg_write_val}, 0);
        check({tag, "_flush"}, {flush, redirect_pc}, 0);
        check({tag, "_trap"}, {trap_valid, trap_cause, trap_val, trap_epc}, 0);
        check({tag, "_retire"}, retire_count, 0);
    endtask

    // Called while flush is high: a bundle offered now must vanish.
    task automatic flush_shadow();
        ex_valid = 1; ex_rd = 5'($urandom_range(1, 31)); ex_rd_val = $urandom;
        ex_store_valid = 0; ex_exception_valid = 0; ex_jump = 0;
        check("shadow_stall", ex_stall, 1);
        step();
        ex_valid = 0;
        check("shadow_no_wen", reg_write_en, 0);
        check("shadow_no_flush", flush, 0);
        check("shadow_no_trap", trap_valid, 0);
        check("shadow_retire", retire_count, exp_retire);
        check("shadow_stall_rel", ex_stall, 0);
    endtask

    task automatic do_alu(input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc,
                          input logic jump, input logic [31:0] jpc);
        check("alu_stall_pre", ex_stall, 0);
        ex_valid = 1; ex_rd = rd; ex_rd_val = val; ex_inst_pc = pc; ex_jump = jump;
        ex_jump_pc = jpc; ex_exception_valid = 0; ex_store_valid = 0;
        step();
        ex_valid = 0;
        check("alu_wen", reg_write_en, rd != 0);
        if (rd != 0) begin
            check("alu_waddr", reg_write_addr, rd);
            check("alu_wval", reg_write_val, val);
        end
        exp_retire++;
        check("alu_retire", retire_count, exp_retire);
        check("alu_trap", trap_valid, 0);
        check("alu_flush", flush, jump);
        if (jump) begin
            check("alu_redirect", redirect_pc, jpc);
            flush_shadow();
        end
    endtask

    task automatic do_exc(input logic [5:0] num, input logic [31:0] val, input logic [31:0] pc);
        check("exc_stall_pre", ex_stall, 0);
        ex_valid = 1; ex_exception_valid = 1; ex_exception_num = num; ex_exception_val = val;
        ex_inst_pc = pc; ex_rd = 5'($urandom_range(1, 31)); ex_store_valid = 1'($urandom);
        ex_jump = 1'($urandom); ex_jump_pc = $urandom;
        step();
        ex_valid = 0; ex_exception_valid = 0; ex_store_valid = 0;
        check("exc_trap", trap_valid, 1);
        check("exc_cause", trap_cause, num);
        check("exc_val", trap_val, val);
        check("exc_epc", trap_epc, pc);
        check("exc_flush", flush, 1);
        check("exc_redirect", redirect_pc, TV);
        check("exc_no_wen", reg_write_en, 0);
        check("exc_no_store", mem_store_valid, 0);
        check("exc_retire", retire_count, exp_retire);
        flush_shadow();
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] val, input logic [1:0] size,
                            input logic [31:0] pc, input logic jump, input logic [31:0] jpc,
                            input int delay, input logic fault, input logic done_too);
        check("st_stall_pre", ex_stall, 0);
        ex_valid = 1; ex_store_valid = 1; ex_store_addr = addr; ex_store_val = val;
        ex_store_size = size; ex_inst_pc = pc; ex_jump = jump; ex_jump_pc = jpc;
        ex_exception_valid = 0; ex_rd = 5'($urandom_range(1, 31));
        step();
        ex_valid = 0; ex_store_valid = 0; ex_store_addr = $urandom; ex_store_val = $urandom;
        for (int i = 0; i < delay; i++) begin
            check("st_req", mem_store_valid, 1);
            check("st_addr", mem_store_addr, addr);
            check("st_val", mem_store_val, val);
            check("st_size", mem_store_size, size);
            check("st_stall", ex_stall, 1);
            check("st_no_wen", reg_write_en, 0);
            check("st_retire_hold", retire_count, exp_retire);
            if (i == delay - 1) begin
                mem_store_access_fault = fault;
                mem_store_done = !fault || done_too;
            end
            step();
        end
        mem_store_done = 0; mem_store_access_fault = 0;
        check("st_req_drop", mem_store_valid, 0);
        if (fault) begin
            check("stf_trap", trap_valid, 1);
            check("stf_cause", trap_cause, 6'd7);
            check("stf_val", trap_val, addr);
            check("stf_epc", trap_epc, pc);
            check("stf_flush", flush, 1);
            check("stf_redirect", redirect_pc, TV);
            check("stf_retire", retire_count, exp_retire);
            flush_shadow();
        end else begin
            exp_retire++;
            check("st_retire", retire_count, exp_retire);
            check("st_trap", trap_valid, 0);
            check("st_flush", flush, jump);
            if (jump) begin
                check("st_redirect", redirect_pc, jpc);
                flush_shadow();
            end else begin
                check("st_stall_rel", ex_stall, 0);
            end
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        #1;
        check_all_zero("rst");
        step();
        step();
        reset = 0;
        step();
        check_all_zero("post_rst");

        do_alu(5'd5, 32'hDEADBEEF, 32'h10, 0, 0);
        do_alu(5'd0, 32'h11111111, 32'h14, 0, 0);
        do_alu(5'd3, 32'h33333333, 32'h18, 0, 0);
        do_store(32'h1000, 32'h12345678, 2'd2, 32'h1C, 0, 0, 3, 0, 0);
        do_store(32'h1000, 32'hCAFEF00D, 2'd2, 32'h200, 0, 0, 2, 1, 1);
        do_alu(5'd7, 32'h77, 32'h300, 1, 32'h400);
        do_exc(6'd2, 32'hBAD0BAD0, 32'h80);

        // Reset while a store request is outstanding.
        ex_valid = 1; ex_store_valid = 1; ex_store_addr = 32'h2000; ex_store_val = 32'h55;
        ex_store_size = 2'd1; ex_inst_pc = 32'h90;
        step();
        clear_inputs();
        check("rst_st_req", mem_store_valid, 1);
        #2 reset = 1;
        #1;
        check_all_zero("mid_rst");
        step();
        reset = 0;
        exp_retire = 0;
        step();
        check_all_zero("after_mid_rst");
        do_alu(5'd9, 32'h99, 32'h100, 0, 0);

        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k <= 3)
                do_alu(5'($urandom_range(0, 31)), $urandom, $urandom, 0, 0);
            else if (k == 4)
                do_alu(5'($urandom_range(0, 31)), $urandom, $urandom, 1, $urandom);
            else if (k <= 6)
                do_store($urandom, $urandom, 2'($urandom_range(0, 2)), $urandom, 1'($urandom),
                         $urandom, $urandom_range(1, 4), 0, 0);
            else if (k == 7)
                do_store($urandom, $urandom, 2'($urandom_range(0, 2)), $urandom, 1'($urandom),
                         $urandom, $urandom_range(1, 4), 1, 1'($urandom));
            else if (k == 8)
                do_exc(6'($urandom), $urandom, $urandom);
            else begin
                step();
                check("idle_no_wen", reg_write_en, 0);
                check("idle_retire", retire_count, exp_retire);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
